// File: rtl/answer_scorer_if.sv
// Player-side bus of the answer scorer.
// Inputs to the scorer:
//   start      - one-cycle pulse, new question shown and expected valid
//   expected   - datapath result for the current question
//   answer     - player answer from the switches
//   submit     - one-cycle pulse, player commits the answer
// Outputs from the scorer:
//   busy       - scorer is in a round (not idle)
//   verdict    - 00 none, 01 correct, 10 wrong, 11 timeout
//   secs_left  - remaining seconds for the hex display
//   cur_score  - current streak score
//   high_score - best score since reset
//   round_done - one-cycle pulse when the verdict display period ends
// master: game side (drives start/expected/answer/submit).
// slave : answer_scorer.
interface answer_scorer_if;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 2;

  logic          start;
  logic [DW-1:0] expected;
  logic [DW-1:0] answer;
  logic          submit;
  logic          busy;
  logic [VW-1:0] verdict;
  logic [DW-1:0] secs_left;
  logic [DW-1:0] cur_score;
  logic [DW-1:0] high_score;
  logic          round_done;

  modport master (
    output start, expected, answer, submit,
    input  busy, verdict, secs_left, cur_score, high_score, round_done
  );

  modport slave (
    input  start, expected, answer, submit,
    output busy, verdict, secs_left, cur_score, high_score, round_done
  );
endinterface

// File: rtl/answer_scorer.sv
// Answer scorer for the binary math game.
// Latches the expected result on start, runs a per-question seconds
// countdown, captures the player's answer on submit, judges it, keeps the
// current and high scores, holds the verdict for HOLD_SECS seconds and then
// pulses round_done back to the game control FSM.
//
// Parameters:
//   CLK_DIV    - clk cycles per one-second tick
//   TIME_LIMIT - seconds allowed per question (1..255)
//   HOLD_SECS  - seconds the verdict is shown before round_done (1..255)
// Ports:
//   clk    - system clock
//   resetn - synchronous active-low reset
//   bus    - answer_scorer_if.slave (start/expected/answer/submit in,
//            busy/verdict/secs_left/cur_score/high_score/round_done out;
//            all outputs registered)
// Build option:
//   ANSWER_SCORER_STREAK_BONUS_EN - when defined, the third and later
//   consecutive correct answers score 2 instead of 1.
module answer_scorer #(
  parameter int unsigned CLK_DIV    = 50000000,
  parameter int unsigned TIME_LIMIT = 10,
  parameter int unsigned HOLD_SECS  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  answer_scorer_if.slave     bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 2;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [VW-1:0] V_NONE    = 2'b00;
  localparam logic [VW-1:0] V_CORRECT = 2'b01;
  localparam logic [VW-1:0] V_WRONG   = 2'b10;
  localparam logic [VW-1:0] V_TIMEOUT = 2'b11;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] SECS_INIT  = DW'(TIME_LIMIT);
  localparam logic [DW-1:0] HOLD_LAST  = DW'(HOLD_SECS - 1);
  localparam logic [DW-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    JUDGE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [DW-1:0] ans_q, ans_d;
  logic          timeout_q, timeout_d;
  logic [DW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] secs_q, secs_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] high_q, high_d;
  logic [VW-1:0] verdict_q, verdict_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          counting_c;
  logic          tick_c;
  logic          correct_c;
  logic [1:0]    inc_c;
  logic [DW:0]   sum_c;
  logic [DW-1:0] sat_score_c;

  // Seconds prescaler only runs while waiting on the player or showing a verdict.
  assign counting_c = (state_q == ARMED) || (state_q == HOLD);
  assign tick_c     = counting_c && (presc_q == PRESC_LAST);

  // A timed-out question can never be correct, whatever ans_q holds.
  assign correct_c  = !timeout_q && (ans_q == exp_q);

`ifdef ANSWER_SCORER_STREAK_BONUS_EN
  logic [1:0] streak_q, streak_d;

  // Two or more correct answers already in a row earn the bonus.
  assign inc_c = (streak_q >= 2'd2) ? 2'd2 : 2'd1;
`else
  assign inc_c = 2'd1;
`endif

  // Saturating score increment.
  assign sum_c       = {1'b0, cur_q} + (DW+1)'(inc_c);
  assign sat_score_c = sum_c[DW] ? SCORE_MAX : sum_c[DW-1:0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    exp_d      = exp_q;
    ans_d      = ans_q;
    timeout_d  = timeout_q;
    hold_cnt_d = hold_cnt_q;
    secs_d     = secs_q;
    cur_d      = cur_q;
    high_d     = high_q;
    verdict_d  = verdict_q;
    done_d     = 1'b0;
`ifdef ANSWER_SCORER_STREAK_BONUS_EN
    streak_d   = streak_q;
`endif

    case (state_q)
      IDLE: begin
        verdict_d = V_NONE;
        if (bus.start) begin
          exp_d     = bus.expected;
          secs_d    = SECS_INIT;
          timeout_d = 1'b0;
          state_d   = ARMED;
        end
      end

      ARMED: begin
        // Every tick decrements, even one coinciding with submit.
        if (tick_c && (secs_q != '0)) begin
          secs_d = secs_q - DW'(1);
        end
        // Submit takes priority over an expiring tick in the same cycle.
        if (bus.submit) begin
          ans_d   = bus.answer;
          state_d = JUDGE;
        end else if (tick_c && (secs_q == DW'(1))) begin
          timeout_d = 1'b1;
          state_d   = JUDGE;
        end
      end

      JUDGE: begin
        if (correct_c) begin
          verdict_d = V_CORRECT;
          cur_d     = sat_score_c;
`ifdef ANSWER_SCORER_STREAK_BONUS_EN
          if (streak_q != 2'd3) begin
            streak_d = streak_q + 2'd1;
          end
`endif
        end else begin
          verdict_d = timeout_q ? V_TIMEOUT : V_WRONG;
          // High score only moves when a streak ends.
          if (cur_q > high_q) begin
            high_d = cur_q;
          end
          cur_d = '0;
`ifdef ANSWER_SCORER_STREAK_BONUS_EN
          streak_d = 2'd0;
`endif
        end
        hold_cnt_d = '0;
        state_d    = HOLD;
      end

      HOLD: begin
        if (tick_c) begin
          if (hold_cnt_q == HOLD_LAST) begin
            done_d    = 1'b1;
            verdict_d = V_NONE;
            state_d   = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + DW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Restart the prescaler on every state entry so the first tick lands
    // exactly CLK_DIV cycles later.
    if ((state_d != state_q) || !counting_c || tick_c) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      exp_q      <= '0;
      ans_q      <= '0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      secs_q     <= '0;
      cur_q      <= '0;
      high_q     <= '0;
      verdict_q  <= V_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      exp_q      <= exp_d;
      ans_q      <= ans_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      secs_q     <= secs_d;
      cur_q      <= cur_d;
      high_q     <= high_d;
      verdict_q  <= verdict_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef ANSWER_SCORER_STREAK_BONUS_EN
  // Consecutive-correct counter, saturating at 3.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      streak_q <= 2'd0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

  assign bus.busy       = busy_q;
  assign bus.verdict    = verdict_q;
  assign bus.secs_left  = secs_q;
  assign bus.cur_score  = cur_q;
  assign bus.high_score = high_q;
  assign bus.round_done = done_q;

endmodule

// File: tb/tb_answer_scorer.sv
// Directed bench for answer_scorer with a scoreboard of expected verdicts
// and scores, filled when a question is answered or left to time out.
module tb_answer_scorer;
  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned TIME_LIMIT = 3;
  localparam int unsigned HOLD_SECS  = 2;
  localparam int unsigned HOLD_CYC   = CLK_DIV * HOLD_SECS;

`ifdef ANSWER_SCORER_STREAK_BONUS_EN
  localparam int unsigned THIRD_SCORE = 4;
`else
  localparam int unsigned THIRD_SCORE = 3;
`endif

  typedef struct {
    logic [1:0] verdict;
    logic [7:0] cur;
    logic [7:0] high;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cur;
  int   m_high;
`ifdef ANSWER_SCORER_STREAK_BONUS_EN
  int   m_streak;
`endif

  answer_scorer_if bus();

  answer_scorer #(
    .CLK_DIV    (CLK_DIV),
    .TIME_LIMIT (TIME_LIMIT),
    .HOLD_SECS  (HOLD_SECS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cur  = 0;
    m_high = 0;
`ifdef ANSWER_SCORER_STREAK_BONUS_EN
    m_streak = 0;
`endif
    sb.delete();
  endtask

  // Reference scoring for one judged question.
  task automatic model_push(input logic [7:0] e, input logic [7:0] a, input bit to);
    exp_t x;
    int   inc;
    if (!to && (a == e)) begin
      inc = 1;
`ifdef ANSWER_SCORER_STREAK_BONUS_EN
      if (m_streak >= 2) inc = 2;
      if (m_streak < 3) m_streak++;
`endif
      m_cur = (m_cur + inc > 255) ? 255 : m_cur + inc;
      x.verdict = 2'b01;
    end else begin
      if (m_cur > m_high) m_high = m_cur;
      m_cur = 0;
`ifdef ANSWER_SCORER_STREAK_BONUS_EN
      m_streak = 0;
`endif
      x.verdict = to ? 2'b11 : 2'b10;
    end
    x.cur  = 8'(m_cur);
    x.high = 8'(m_high);
    sb.push_back(x);
  endtask

  task automatic check_sb(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end else begin
      x = sb.pop_front();
      chk({tag, "_verdict"}, 32'(bus.verdict), 32'(x.verdict));
      chk({tag, "_cur"},     32'(bus.cur_score), 32'(x.cur));
      chk({tag, "_high"},    32'(bus.high_score), 32'(x.high));
    end
  endtask

  // Wait for a verdict; n0 cycles have already elapsed toward lat.
  task automatic wait_verdict(input int n0, input int lat, input string tag);
    int n;
    n = n0;
    do begin
      cyc();
      n++;
    end while ((bus.verdict == 2'b00) && (n < 40));
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check_sb(tag);
  endtask

  task automatic wait_done(input int lat, input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while ((bus.round_done !== 1'b1) && (n < 60));
    chk({tag, "_done_lat"}, 32'(n), 32'(lat));
    chk({tag, "_idle_verdict"}, 32'(bus.verdict), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    cyc();
    chk({tag, "_done_pulse"}, 32'(bus.round_done), 32'd0);
  endtask

  task automatic start_q(input logic [7:0] e);
    bus.expected = e;
    bus.start    = 1'b1;
    cyc();
    bus.start    = 1'b0;
  endtask

  // Drive submit for one cycle; returns in the JUDGE cycle.
  task automatic submit_a(input logic [7:0] a, input string tag);
    bus.answer = a;
    bus.submit = 1'b1;
    cyc();
    bus.submit = 1'b0;
    chk({tag, "_judge_v0"}, 32'(bus.verdict), 32'd0);
  endtask

  task automatic play_round(input logic [7:0] e, input logic [7:0] a, input int delay,
                            input string tag);
    start_q(e);
    repeat (delay) cyc();
    model_push(e, a, 1'b0);
    submit_a(a, tag);
    wait_verdict(1, 2, tag);
    wait_done(HOLD_CYC, tag);
  endtask

  initial begin
    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.submit   = 1'b0;
    bus.expected = '0;
    bus.answer   = '0;
    model_reset();
    repeat (3) cyc();
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_verdict", 32'(bus.verdict), 32'd0);
    chk("rst_secs",    32'(bus.secs_left), 32'd0);
    chk("rst_cur",     32'(bus.cur_score), 32'd0);
    chk("rst_high",    32'(bus.high_score), 32'd0);
    chk("rst_done",    32'(bus.round_done), 32'd0);
    resetn = 1'b1;
    cyc();

    // Submit while idle is ignored.
    bus.answer = 8'd5;
    bus.submit = 1'b1;
    cyc();
    bus.submit = 1'b0;
    chk("idle_sub_busy", 32'(bus.busy), 32'd0);
    cyc();
    chk("idle_sub_verdict", 32'(bus.verdict), 32'd0);

    // Correct answer, submit two cycles after start.
    start_q(8'd12);
    chk("a_armed_busy", 32'(bus.busy), 32'd1);
    chk("a_armed_secs", 32'(bus.secs_left), 32'(TIME_LIMIT));
    model_push(8'd12, 8'd12, 1'b0);
    submit_a(8'd12, "a");
    wait_verdict(1, 2, "a");
    chk("a_cur_lit", 32'(bus.cur_score), 32'd1);
    wait_done(HOLD_CYC, "a");
    chk("a_secs_hold", 32'(bus.secs_left), 32'd3);

    // Two more correct rounds, then a miss ends the streak.
    play_round(8'd5, 8'd5, 2, "b");
    play_round(8'd200, 8'd200, 0, "c");
    chk("c_cur_lit", 32'(bus.cur_score), 32'(THIRD_SCORE));
    play_round(8'd8, 8'd7, 1, "w1");
    chk("w1_high_lit", 32'(bus.high_score), 32'(THIRD_SCORE));
    chk("w1_cur_lit",  32'(bus.cur_score), 32'd0);
    play_round(8'd100, 8'd100, 0, "d");
    play_round(8'd3, 8'd131, 0, "w2");
    chk("w2_high_lit", 32'(bus.high_score), 32'(THIRD_SCORE));

    // Timeout after a correct answer.
    play_round(8'd60, 8'd60, 0, "e");
    start_q(8'd50);
    chk("to_secs_0", 32'(bus.secs_left), 32'd3);
    model_push(8'd50, 8'd0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if ((i % 4) == 0) chk($sformatf("to_secs_%0d", i), 32'(bus.secs_left), 32'(3 - i / 4));
    end
    wait_verdict(12, 13, "to");
    chk("to_verdict_lit", 32'(bus.verdict), 32'd3);
    chk("to_cur_lit", 32'(bus.cur_score), 32'd0);
    wait_done(HOLD_CYC, "to");

    // Submit on the expiring tick wins.
    start_q(8'd77);
    repeat (11) cyc();
    model_push(8'd77, 8'd77, 1'b0);
    submit_a(8'd77, "tie");
    chk("tie_secs_judge", 32'(bus.secs_left), 32'd0);
    wait_verdict(1, 2, "tie");
    chk("tie_verdict_lit", 32'(bus.verdict), 32'd1);
    chk("tie_secs", 32'(bus.secs_left), 32'd0);
    wait_done(HOLD_CYC, "tie");

    // start in ARMED and start/submit in HOLD are ignored.
    start_q(8'd40);
    cyc();
    bus.expected = 8'd41;
    bus.start    = 1'b1;
    cyc();
    bus.start    = 1'b0;
    model_push(8'd40, 8'd40, 1'b0);
    submit_a(8'd40, "ign");
    wait_verdict(1, 2, "ign");
    bus.expected = 8'd9;
    bus.answer   = 8'd9;
    bus.start    = 1'b1;
    bus.submit   = 1'b1;
    cyc();
    bus.start    = 1'b0;
    bus.submit   = 1'b0;
    chk("ign_hold_verdict", 32'(bus.verdict), 32'd1);
    chk("ign_hold_busy", 32'(bus.busy), 32'd1);
    wait_done(HOLD_CYC - 1, "ign");
    chk("ign_cur", 32'(bus.cur_score), 32'(m_cur));
    cyc();
    chk("ign_stay_idle", 32'(bus.busy), 32'd0);

    // Reset from the middle of a question.
    start_q(8'd99);
    repeat (5) cyc();
    resetn = 1'b0;
    cyc();
    cyc();
    chk("rst2_busy",    32'(bus.busy), 32'd0);
    chk("rst2_verdict", 32'(bus.verdict), 32'd0);
    chk("rst2_secs",    32'(bus.secs_left), 32'd0);
    chk("rst2_cur",     32'(bus.cur_score), 32'd0);
    chk("rst2_high",    32'(bus.high_score), 32'd0);
    chk("rst2_done",    32'(bus.round_done), 32'd0);
    resetn = 1'b1;
    model_reset();
    cyc();
    play_round(8'd1, 8'd1, 0, "post_rst");
    chk("post_rst_cur_lit", 32'(bus.cur_score), 32'd1);

    // Score saturates at 255.
    for (int r = 0; r < 256; r++) play_round(8'(r), 8'(r), 0, "sat");
    chk("sat_cur_lit", 32'(bus.cur_score), 32'd255);
    play_round(8'd1, 8'd2, 0, "sat_miss");
    chk("sat_high_lit", 32'(bus.high_score), 32'd255);

    // Three consecutive correct answers from zero.
    play_round(8'd10, 8'd10, 0, "st1");
    chk("st1_lit", 32'(bus.cur_score), 32'd1);
    play_round(8'd11, 8'd11, 0, "st2");
    chk("st2_lit", 32'(bus.cur_score), 32'd2);
    play_round(8'd12, 8'd12, 0, "st3");
    chk("st3_lit", 32'(bus.cur_score), 32'(THIRD_SCORE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
